// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
// Bus between the EXE stage and the iterative multiply/divide unit.
// The master side (pipeline) drives the request, operands, flush and
// MTHI/MTLO write fields. The slave side (unit) returns HI/LO, busy,
// the done pulse and the pipeline stall request.
//   enable     global execution enable (freezes the unit when low)
//   start/op   new operation request and select (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand_a  multiplicand / dividend (rs)
//   operand_b  multiplier / divisor (rt)
//   flush      abort the in-flight operation
//   hi_wen/lo_wen/wdata  direct HI/LO writes
//   hi/lo      result registers
//   busy/stall_req  operation in flight
//   done       one-cycle result pulse
interface mul_div_unit_if #(parameter int DATA_W = 32);
   logic              enable;
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic              flush;
   logic              hi_wen;
   logic              lo_wen;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              busy;
   logic              done;
   logic              stall_req;

   modport master (
      output enable, start, op, operand_a, operand_b, flush, hi_wen, lo_wen, wdata,
      input  hi, lo, busy, done, stall_req
   );

   modport slave (
      input  enable, start, op, operand_a, operand_b, flush, hi_wen, lo_wen, wdata,
      output hi, lo, busy, done, stall_req
   );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit with HI/LO registers for MULT, MULTU,
// DIV and DIVU. One shift-add or restoring-divide step per enabled cycle,
// DATA_W steps per operation followed by one sign-fix cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mul_div_unit_if slave modport (request, operands, HI/LO, status)
module mul_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   mul_div_unit_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                is_div;
   logic                sign_a;
   logic                sign_b;
   logic [DATA_W-1:0]   mag_a;
   logic [DATA_W-1:0]   mag_b;
   // Shared accumulator: multiply keeps {partial product, multiplier},
   // divide keeps {remainder, dividend/quotient}.
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;
   logic                busy_q;
   logic                done_q;

   logic                start_signed;
   logic                start_neg_a;
   logic                start_neg_b;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W-1:0]   div_diff;
   logic [2*DATA_W-1:0] div_next;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   raw_a;
   logic [DATA_W-1:0]   res_hi;
   logic [DATA_W-1:0]   res_lo;

   assign start_signed = ~bus.op[0];
   assign start_neg_a  = start_signed & bus.operand_a[DATA_W-1];
   assign start_neg_b  = start_signed & bus.operand_b[DATA_W-1];

   // One iteration of each algorithm plus the sign-fixed result. The
   // remainder never exceeds the divisor, so the trial difference fits
   // in DATA_W bits whenever the subtraction is taken.
   always_comb begin
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
      mul_next  = {mul_sum, acc[DATA_W-1:1]};
      div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      div_diff  = div_shift[DATA_W-1:0] - mag_b;
      if (div_shift >= {1'b0, mag_b}) begin
         div_next = {div_diff, acc[DATA_W-2:0], 1'b1};
      end else begin
         div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end

      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      raw_a    = sign_a ? -mag_a : mag_a;
      res_hi   = prod_fix[2*DATA_W-1:DATA_W];
      res_lo   = prod_fix[DATA_W-1:0];
      if (is_div) begin
         if (mag_b == '0) begin
            res_hi = raw_a;
            res_lo = '1;
         end else begin
            res_hi = sign_a ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            res_lo = (sign_a ^ sign_b) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
         end
      end
   end

   // Control FSM and datapath registers. done is cleared every edge so it
   // can only be a single-cycle pulse; flush wins over everything but rst
   // and also drops any direct writes presented with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
         end else if (bus.enable) begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     cnt    <= '0;
                     is_div <= bus.op[1];
                     sign_a <= start_neg_a;
                     sign_b <= start_neg_b;
                     mag_a  <= start_neg_a ? -bus.operand_a : bus.operand_a;
                     mag_b  <= start_neg_b ? -bus.operand_b : bus.operand_b;
                     if (bus.op[1]) begin
                        acc <= {{DATA_W{1'b0}}, (start_neg_a ? -bus.operand_a : bus.operand_a)};
                     end else begin
                        acc <= {{DATA_W{1'b0}}, (start_neg_b ? -bus.operand_b : bus.operand_b)};
                     end
                  end else begin
                     if (bus.hi_wen) hi_q <= bus.wdata;
                     if (bus.lo_wen) lo_q <= bus.wdata;
                  end
               end
               RUN: begin
                  acc <= is_div ? div_next : mul_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_STEP) state <= FIX;
               end
               FIX: begin
                  hi_q   <= res_hi;
                  lo_q   <= res_lo;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stall_req = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Self-checking bench for mul_div_unit (DATA_W = 32). Expected HI/LO
// results are pushed to a scoreboard queue when an operation is started
// and popped when the unit pulses done.
module tb_mul_div_unit;
   localparam int DATA_W = 32;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   done_pulses = 0;
   logic [31:0] last_hi;
   logic [31:0] last_lo;
   int   lat;
   int   busy_cnt;
   int   pulses_before;

   always #5 clk = ~clk;

   mul_div_unit_if #(.DATA_W(DATA_W)) bus();

   mul_div_unit #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Count every done pulse seen on the falling edge.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_pulses++;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model of the four operations, returns {hi, lo}.
   function automatic logic [63:0] modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     sa;
      int     sbv;
      int     q;
      int     r;
      logic [63:0] res;
      res = '0;
      case (op)
         2'b00: begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p;
         end
         2'b01: res = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
            else begin
               sa  = $signed(a);
               sbv = $signed(b);
               q   = sa / sbv;
               r   = sa % sbv;
               res = {32'(r), 32'(q)};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Present start for one cycle; the edge that ends the task is E0.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] expv, input bit push, input string tag);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      if (push) sb.push_back('{hi: expv[63:32], lo: expv[31:0], tag: tag});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait for done after E0 (bounded), optionally dropping enable for
   // stall_len cycles and poking start/hi_wen while busy, then compare
   // HI/LO against the scoreboard head.
   task automatic waitDone(input int stall_at, input int stall_len, output int lat_o, output int busy_o);
      exp_t e;
      lat_o  = 0;
      busy_o = (bus.busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         bus.start  = 1'b0;
         bus.hi_wen = 1'b0;
         if (bus.done === 1'b1) begin
            lat_o = i;
            break;
         end
         if (bus.busy === 1'b1) busy_o++;
         bus.enable = !(stall_len > 0 && i >= stall_at && i < stall_at + stall_len);
         if (stall_len > 0 && (i == stall_at - 2 || i == stall_at + 1)) begin
            bus.start  = 1'b1;
            bus.op     = 2'b11;
            bus.hi_wen = 1'b1;
            bus.wdata  = 32'hDEAD_BEEF;
         end
      end
      bus.enable = 1'b1;
      if (lat_o == 0) checkOutput("done_timeout", 64'd0, 64'd1);
      if (sb.size() == 0) begin
         checkOutput("sb_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
         checkOutput({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
         last_hi = e.hi;
         last_lo = e.lo;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      rst           = 1'b1;
      bus.enable    = 1'b1;
      bus.start     = 1'b0;
      bus.op        = 2'b00;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.flush     = 1'b0;
      bus.hi_wen    = 1'b0;
      bus.lo_wen    = 1'b0;
      bus.wdata     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset values");
      checkOutput("rst_hi", 64'(bus.hi), 64'h0);
      checkOutput("rst_lo", 64'(bus.lo), 64'h0);
      checkOutput("rst_busy", 64'(bus.busy), 64'h0);
      checkOutput("rst_done", 64'(bus.done), 64'h0);
      checkOutput("rst_stall", 64'(bus.stall_req), 64'h0);

      $display("[TB] MULTU max x max, latency and busy length");
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1, "multu_max");
      checkOutput("busy_after_e0", 64'(bus.busy), 64'h1);
      checkOutput("stall_after_e0", 64'(bus.stall_req), 64'h1);
      waitDone(0, 0, lat, busy_cnt);
      checkOutput("multu_latency", 64'(lat), 64'd33);
      checkOutput("multu_busy_cycles", 64'(busy_cnt), 64'd33);
      checkOutput("busy_at_done", 64'(bus.busy), 64'h0);

      $display("[TB] signed multiply/divide, back-to-back");
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b1, "mult_neg");
      waitDone(0, 0, lat, busy_cnt);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, "div_neg");
      waitDone(0, 0, lat, busy_cnt);
      checkOutput("div_latency", 64'(lat), 64'd33);

      $display("[TB] boundary divides");
      applyStimulus(2'b11, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, "divu_zero");
      waitDone(0, 0, lat, busy_cnt);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, "div_zero_neg");
      waitDone(0, 0, lat, busy_cnt);
      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1, "div_ovf");
      waitDone(0, 0, lat, busy_cnt);

      $display("[TB] random operations against the model");
      for (int k = 0; k < 8; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (k == 3) ? 32'($urandom_range(1, 15)) : $urandom;
         if (k == 5) ra = 32'($urandom_range(0, 1000));
         applyStimulus(rop, ra, rb, modelOp(rop, ra, rb), 1'b1, "rand");
         waitDone(0, 0, lat, busy_cnt);
      end
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", 64'(bus.done), 64'h0);

      $display("[TB] flush mid-operation");
      bus.hi_wen = 1'b1;
      bus.wdata  = 32'hAAAA_0000;
      @(posedge clk);
      #1;
      bus.hi_wen = 1'b0;
      checkOutput("mthi", 64'(bus.hi), 64'hAAAA_0000);
      pulses_before = done_pulses;
      applyStimulus(2'b01, 32'd7, 32'd9, 64'h0, 1'b0, "flushed");
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checkOutput("flush_busy", 64'(bus.busy), 64'h0);
      checkOutput("flush_hi", 64'(bus.hi), 64'hAAAA_0000);
      checkOutput("flush_lo", 64'(bus.lo), 64'(last_lo));
      repeat (40) @(posedge clk);
      #1;
      checkOutput("flush_no_done", 64'(done_pulses), 64'(pulses_before));

      $display("[TB] flush in idle suppresses start");
      bus.flush = 1'b1;
      applyStimulus(2'b01, 32'd3, 32'd3, 64'h0, 1'b0, "flush_idle");
      bus.flush = 1'b0;
      checkOutput("flush_idle_busy", 64'(bus.busy), 64'h0);

      $display("[TB] reset mid-operation");
      applyStimulus(2'b01, 32'd7, 32'd9, 64'h0, 1'b0, "reset_abort");
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_mid_hi", 64'(bus.hi), 64'h0);
      checkOutput("rst_mid_lo", 64'(bus.lo), 64'h0);
      checkOutput("rst_mid_busy", 64'(bus.busy), 64'h0);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("rst_mid_no_done", 64'(done_pulses), 64'(pulses_before));

      $display("[TB] enable stall with ignored pulses");
      applyStimulus(2'b01, 32'h0000_1234, 32'h0000_5678, modelOp(2'b01, 32'h0000_1234, 32'h0000_5678), 1'b1, "en_stall");
      waitDone(5, 5, lat, busy_cnt);
      checkOutput("en_latency", 64'(lat), 64'd38);
      checkOutput("en_busy_cycles", 64'(busy_cnt), 64'd38);

      $display("[TB] MTLO and start/lo_wen collision");
      bus.lo_wen = 1'b1;
      bus.wdata  = 32'h0000_0055;
      @(posedge clk);
      #1;
      bus.lo_wen = 1'b0;
      checkOutput("mtlo", 64'(bus.lo), 64'h55);
      bus.lo_wen = 1'b1;
      bus.wdata  = 32'h0000_0BAD;
      applyStimulus(2'b01, 32'd6, 32'd7, {32'h0, 32'd42}, 1'b1, "start_wins");
      bus.lo_wen = 1'b0;
      checkOutput("lo_write_dropped", 64'(bus.lo), 64'h55);
      waitDone(0, 0, lat, busy_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
